// File: rtl/dvg_vector_timer.sv
// -----------------------------------------------------------------------------
// dvg_vector_timer
//
// Drawing stage behind the DVG state machine. When go rises it latches the
// vector operands. It then runs for a scale-dependent number of cycles N.
// During the run, a pair of DDA rate multipliers produce X/Y beam step pulses,
// floor(d*N/2^DW) per axis. At the end it raises stop until go is released.
//
// Optional feature (macro DVG_GLOBAL_SCALE_EN): adds input gscale. It shortens
// every drawing run to max(1, N >> gscale).
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   go       in   draw request level from the state machine
//   op       in   opcode: 0x0-0x9 VCTR scale, 0xF SVEC, others non-drawing
//   sscale   in   SVEC scale field
//   dx, dy   in   X/Y magnitudes (DW bits)
//   xsign    in   X direction, 1 = negative
//   ysign    in   Y direction, 1 = negative
//   zin      in   intensity
//   gscale   in   global scale shift (only with DVG_GLOBAL_SCALE_EN)
//   xstep    out  one-cycle X step pulse
//   ystep    out  one-cycle Y step pulse
//   xdir     out  registered X direction
//   ydir     out  registered Y direction
//   zout     out  registered intensity
//   beam_on  out  high while running with nonzero intensity
//   stop     out  vector-complete level
// -----------------------------------------------------------------------------
module dvg_vector_timer #(
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          go,
   input  logic [3:0]    op,
   input  logic [1:0]    sscale,
   input  logic [DW-1:0] dx,
   input  logic [DW-1:0] dy,
   input  logic          xsign,
   input  logic          ysign,
   input  logic [3:0]    zin,
`ifdef DVG_GLOBAL_SCALE_EN
   input  logic [2:0]    gscale,
`endif
   output logic          xstep,
   output logic          ystep,
   output logic          xdir,
   output logic          ydir,
   output logic [3:0]    zout,
   output logic          beam_on,
   output logic          stop
);

   localparam int CW = 11;  // holds N up to 1024

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [DW-1:0] dx_q, dy_q;
   logic [DW-1:0] accx, accy;
   logic [DW:0]   sum_x, sum_y;
   logic [CW-1:0] n_load;

   function automatic logic [CW-1:0] run_len(input logic [3:0] o, input logic [1:0] s);
      logic [CW-1:0] n;
      if (o <= 4'd9)
         n = CW'(1) << (o + 4'd1);
      else if (o == 4'hF)
         n = CW'(1) << ({1'b0, s} + 3'd5);
      else
         n = '0;
      return n;
   endfunction

`ifdef DVG_GLOBAL_SCALE_EN
   function automatic logic [CW-1:0] scale_len(input logic [CW-1:0] n, input logic [2:0] g);
      logic [CW-1:0] r;
      r = n >> g;
      // A drawing op never collapses to an empty run.
      if (n != '0 && r == '0)
         r = CW'(1);
      return r;
   endfunction

   assign n_load = scale_len(run_len(op, sscale), gscale);
`else
   assign n_load = run_len(op, sscale);
`endif

   assign sum_x = {1'b0, accx} + {1'b0, dx_q};
   assign sum_y = {1'b0, accy} + {1'b0, dy_q};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         count   <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         accx    <= '0;
         accy    <= '0;
         xstep   <= 1'b0;
         ystep   <= 1'b0;
         xdir    <= 1'b0;
         ydir    <= 1'b0;
         zout    <= '0;
         beam_on <= 1'b0;
         stop    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               xstep   <= 1'b0;
               ystep   <= 1'b0;
               beam_on <= 1'b0;
               stop    <= 1'b0;
               if (go) begin
                  dx_q <= dx;
                  dy_q <= dy;
                  xdir <= xsign;
                  ydir <= ysign;
                  zout <= zin;
                  if (n_load != '0) begin
                     state   <= RUN;
                     count   <= n_load;
                     // The first accumulation (0 + d) is folded into the start
                     // edge. It can never carry. Each pulse then shows up in the
                     // RUN cycle that produced it, and N additions give exactly
                     // floor(d*N/2^DW) pulses.
                     accx    <= dx;
                     accy    <= dy;
                     beam_on <= (zin != 4'd0);
                  end else begin
                     state <= DONE;
                     stop  <= 1'b1;
                     count <= '0;
                     accx  <= '0;
                     accy  <= '0;
                  end
               end
            end

            RUN: begin
               if (!go) begin
                  // Halt: abort without stop and drop any pending pulse.
                  state   <= IDLE;
                  count   <= '0;
                  accx    <= '0;
                  accy    <= '0;
                  xstep   <= 1'b0;
                  ystep   <= 1'b0;
                  beam_on <= 1'b0;
               end else if (count == CW'(1)) begin
                  state   <= DONE;
                  count   <= '0;
                  xstep   <= 1'b0;
                  ystep   <= 1'b0;
                  beam_on <= 1'b0;
                  stop    <= 1'b1;
               end else begin
                  {xstep, accx} <= sum_x;
                  {ystep, accy} <= sum_y;
                  count         <= count - CW'(1);
               end
            end

            DONE: begin
               xstep   <= 1'b0;
               ystep   <= 1'b0;
               beam_on <= 1'b0;
               if (!go) begin
                  state <= IDLE;
                  stop  <= 1'b0;
                  accx  <= '0;
                  accy  <= '0;
               end
            end

            default: begin
               state <= IDLE;
               stop  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dvg_vector_timer.sv
module tb_dvg_vector_timer;

   localparam int DW = 10;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          go;
   logic [3:0]    op;
   logic [1:0]    sscale;
   logic [DW-1:0] dx, dy;
   logic          xsign, ysign;
   logic [3:0]    zin;
`ifdef DVG_GLOBAL_SCALE_EN
   logic [2:0]    gscale;
`endif
   logic          xstep, ystep, xdir, ydir, beam_on, stop;
   logic [3:0]    zout;

   int n_checks = 0;
   int n_fail   = 0;

   dvg_vector_timer #(.DW(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .go      (go),
      .op      (op),
      .sscale  (sscale),
      .dx      (dx),
      .dy      (dy),
      .xsign   (xsign),
      .ysign   (ysign),
      .zin     (zin),
`ifdef DVG_GLOBAL_SCALE_EN
      .gscale  (gscale),
`endif
      .xstep   (xstep),
      .ystep   (ystep),
      .xdir    (xdir),
      .ydir    (ydir),
      .zout    (zout),
      .beam_on (beam_on),
      .stop    (stop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int outs();
      return int'({xstep, ystep, xdir, ydir, zout, beam_on, stop});
   endfunction

   // Present operands and raise go between edges. After the latching edge,
   // scramble the operands so that any mid-run sensitivity shows up.
   task automatic start_run(input logic [3:0] o, input logic [1:0] s,
                            input int ddx, input int ddy,
                            input logic xs, input logic ys, input logic [3:0] z);
      @(negedge clk);
      op = o; sscale = s; dx = DW'(ddx); dy = DW'(ddy);
      xsign = xs; ysign = ys; zin = z; go = 1'b1;
      @(posedge clk);
      #1;
      op = 4'h3; sscale = 2'd3; dx = ~dx; dy = ~dy;
      xsign = ~xsign; ysign = ~ysign; zin = ~zin;
   endtask

   // Sample each cycle until stop (or max_run RUN cycles when max_run > 0).
   // RUN cycles are recognised by beam_on, so runs use a nonzero intensity.
   task automatic measure(input int max_run, input logic exp_xdir,
                          output int runc, output int xc, output int yc,
                          output int fx, output int fy, output int bad,
                          output int stopped);
      runc = 0; xc = 0; yc = 0; fx = 0; fy = 0; bad = 0; stopped = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (stop) begin
            stopped = 1;
            if (xstep || ystep || beam_on) bad++;
            break;
         end
         if (beam_on) begin
            runc++;
            if (xdir != exp_xdir) bad++;
            if (xstep) begin xc++; if (fx == 0) fx = runc; end
            if (ystep) begin yc++; if (fy == 0) fy = runc; end
         end else begin
            if (xstep || ystep) bad++;
            if (runc > 0) bad++;  // gap between RUN and stop
         end
         if (max_run > 0 && runc == max_run) break;
      end
   endtask

   task automatic hold_and_release(input string tag);
      int hi = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         hi += int'(stop);
      end
      check({tag, "_stop_held"}, hi, 3);
      go = 1'b0;
      @(negedge clk);
      check({tag, "_stop_clear"}, int'(stop), 0);
   endtask

   int runc, xc, yc, fx, fy, bad, stopped, cnt;

   initial begin
      reset_n = 1'b0; go = 1'b0; op = '0; sscale = '0; dx = '0; dy = '0;
      xsign = 1'b0; ysign = 1'b0; zin = '0;
`ifdef DVG_GLOBAL_SCALE_EN
      gscale = '0;
`endif
      repeat (3) @(negedge clk);
      check("reset_outputs", outs(), 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_outputs", outs(), 0);

      // Longest VCTR run, full-scale dx, zero dy.
      start_run(4'h9, 2'd0, 1023, 0, 1'b0, 1'b0, 4'd7);
      measure(0, 1'b0, runc, xc, yc, fx, fy, bad, stopped);
      check("t1_run_cycles", runc, 1024);
      check("t1_xsteps", xc, 1023);
      check("t1_ysteps", yc, 0);
      check("t1_stop", stopped, 1);
      check("t1_bad", bad, 0);
      check("t1_zout", int'(zout), 7);
      hold_and_release("t1");

      // Shortest VCTR run: single pulse per axis on the 2nd cycle.
      start_run(4'h0, 2'd0, 512, 1023, 1'b0, 1'b0, 4'd9);
      measure(0, 1'b0, runc, xc, yc, fx, fy, bad, stopped);
      check("t2_run_cycles", runc, 2);
      check("t2_xsteps", xc, 1);
      check("t2_ysteps", yc, 1);
      check("t2_xstep_cycle", fx, 2);
      check("t2_ystep_cycle", fy, 2);
      check("t2_stop", stopped, 1);
      check("t2_bad", bad, 0);
      hold_and_release("t2");

      // SVEC, smallest scale, negative X.
      start_run(4'hF, 2'd0, 256, 64, 1'b1, 1'b0, 4'd3);
      measure(0, 1'b1, runc, xc, yc, fx, fy, bad, stopped);
      check("t3_run_cycles", runc, 32);
      check("t3_xsteps", xc, 8);
      check("t3_ysteps", yc, 2);
      check("t3_stop", stopped, 1);
      check("t3_bad", bad, 0);
      check("t3_xdir", int'(xdir), 1);
      check("t3_ydir", int'(ydir), 0);
      hold_and_release("t3");

      // Non-drawing op goes straight to DONE.
      start_run(4'hB, 2'd0, 1023, 1023, 1'b0, 1'b0, 4'd5);
      measure(0, 1'b0, runc, xc, yc, fx, fy, bad, stopped);
      check("t4_run_cycles", runc, 0);
      check("t4_steps", xc + yc, 0);
      check("t4_stop", stopped, 1);
      check("t4_beam", int'(beam_on), 0);
      hold_and_release("t4");

      // Halt after 100 RUN cycles.
      start_run(4'h9, 2'd0, 1023, 0, 1'b0, 1'b0, 4'd7);
      measure(100, 1'b0, runc, xc, yc, fx, fy, bad, stopped);
      check("t5_run_cycles", runc, 100);
      check("t5_xsteps", xc, 99);
      go = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cnt += int'(xstep) + int'(ystep) + int'(beam_on) + int'(stop);
      end
      check("t5_quiet_after_halt", cnt, 0);
      start_run(4'h9, 2'd0, 512, 0, 1'b0, 1'b0, 4'd7);
      measure(0, 1'b0, runc, xc, yc, fx, fy, bad, stopped);
      check("t5b_run_cycles", runc, 1024);
      check("t5b_xsteps", xc, 512);
      check("t5b_stop", stopped, 1);
      hold_and_release("t5b");

      // Reset in the middle of a run.
      start_run(4'h5, 2'd0, 1023, 0, 1'b1, 1'b1, 4'd7);
      measure(10, 1'b1, runc, xc, yc, fx, fy, bad, stopped);
      check("t6_pre_run_cycles", runc, 10);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t6_reset_outputs", outs(), 0);
      op = 4'h5; sscale = 2'd0; dx = DW'(1023); dy = '0;
      xsign = 1'b0; ysign = 1'b0; zin = 4'd7;
      @(negedge clk);
      check("t6_reset_held", outs(), 0);
      reset_n = 1'b1;
      measure(0, 1'b0, runc, xc, yc, fx, fy, bad, stopped);
      check("t6_run_cycles", runc, 64);
      check("t6_xsteps", xc, 63);
      check("t6_stop", stopped, 1);
      hold_and_release("t6");

`ifdef DVG_GLOBAL_SCALE_EN
      gscale = 3'd2;
      start_run(4'h9, 2'd0, 1023, 0, 1'b0, 1'b0, 4'd7);
      measure(0, 1'b0, runc, xc, yc, fx, fy, bad, stopped);
      check("t7_run_cycles", runc, 256);
      check("t7_xsteps", xc, 255);
      check("t7_stop", stopped, 1);
      hold_and_release("t7");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dvg_vector_timer.md
Name: dvg_vector_timer

Overview:
- Drawing stage directly downstream of the DVG state machine. Consumes its `go` level and the latched vector operands.
- Generates per-cycle X/Y beam step pulses with a DDA rate multiplier for a scale-dependent run length.
- Asserts `stop` to end the draw; the state machine uses `stop` to clear `go`.
- Feeds the X/Y position counters and the Z (intensity) DAC.

Parameters:
- DW, 10, magnitude width of dx/dy and of the DDA accumulators.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- go  in  1  draw request level from state machine; high from GO_STROBE until stop is seen.
- op  in  4  current opcode: 0x0-0x9 = VCTR scale, 0xF = SVEC, others = non-drawing.
- sscale  in  2  SVEC scale field.
- dx  in  DW  X magnitude.
- dy  in  DW  Y magnitude.
- xsign  in  1  X direction, 1 = negative.
- ysign  in  1  Y direction, 1 = negative.
- zin  in  4  intensity.
- xstep  out  1  one-cycle X step pulse.
- ystep  out  1  one-cycle Y step pulse.
- xdir  out  1  registered X direction.
- ydir  out  1  registered Y direction.
- zout  out  4  registered intensity.
- beam_on  out  1  high while in RUN with zout != 0.
- stop  out  1  vector-complete level.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; accumulators=0; count=0; all outputs 0.
- States: IDLE, RUN, DONE.

IDLE:
- Holds while go=0.
- At the first rising edge with go=1:
  - Latch op, sscale, dx, dy, xsign, ysign and zin.
  - Clear accx and accy.
  - Load the cycle count N:
    - op 0x0-0x9: N = 2^(op+1), giving 2..1024.
    - op 0xF: N = 2^(sscale+5), giving 32..256.
    - any other op: N = 0.
  - Next state: RUN if N>0, else DONE.

RUN:
- Each cycle: {cx,accx} = accx + dx (DW+1-bit sum); xstep = cx, registered. Y is identical using dy and ystep.
- Total pulses over a run = floor(d*N/1024), with d=dx or dy.
- Count decrements by 1 each cycle. The cycle in which the count reaches 0 is the last RUN cycle; the next state is DONE.
- xdir/ydir/zout come from the latched values for the whole run.
- Exactly N RUN cycles occur; step pulses appear only during them.

DONE:
- stop=1; xstep=ystep=beam_on=0.
- stop stays high until go is sampled low; then IDLE with stop=0 on that edge.

Boundary conditions:
- go falls during RUN (halt): abort to IDLE on that edge. No stop; accumulators cleared; pending step pulses suppressed.
- dx=0 or dy=0: no pulses on that axis; run length unchanged.
- dx = 2^DW - 1 with N=1024: 1023 pulses.
- go held high after DONE→IDLE is impossible, since IDLE is entered only with go=0. A new go rising edge starts a fresh run with no carried-over accumulator state.
- Operand inputs changing mid-run are ignored.
- Reset asserted mid-run: immediate IDLE, all outputs 0.

Optional Feature:
- Macro: DVG_GLOBAL_SCALE_EN.
- Defined:
  - Adds input `gscale` [2:0], latched at run start.
  - Effective N = max(1, N >> gscale) for drawing ops. Non-drawing ops keep N=0.
- Undefined:
  - Port absent; N exactly as above.

Test Plan:
- op=9, dx=1023, dy=0, zin=7, go held → exactly 1024 RUN cycles, 1023 xstep, 0 ystep, beam_on high 1024 cycles, then stop=1 until go dropped.
- op=0, dx=512, dy=1023 → 2 RUN cycles; exactly 1 xstep and 1 ystep, both on the 2nd RUN cycle; stop the cycle after.
- op=0xF, sscale=0, dx=256, dy=64, xsign=1 → 32 RUN cycles, 8 xstep and 2 ystep with xdir=1; stop follows.
- op=0xB, go=1 → DONE the next cycle, zero steps, beam_on=0; stop held until go=0, then IDLE.
- op=9, dx=1023; go dropped after 100 RUN cycles → IDLE next edge; no further xstep; stop never asserted. A subsequent run with dx=512 gives 512 steps.
- reset_n pulled low mid-RUN (op=5) → outputs 0 immediately. After release with go=1: a full 64-cycle run.
- Only with DVG_GLOBAL_SCALE_EN: op=9, gscale=2, dx=1023 → 256 RUN cycles, 255 xstep.
